// File: rtl/cache_pkg.sv
// Shared types and constants for the cache miss sequencer.
// Holds the sequencer state encoding and the default bus widths.
package cache_pkg;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned LINE_W   = 512;
  localparam int unsigned OFFSET_W = 6;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    MISS_WAIT = 3'd2,
    FILL      = 3'd3,
    RESP      = 3'd4
  } state_t;

endpackage

// File: rtl/cache_miss_sequencer_sat_counter.sv
// Saturating up-counter for hit/miss statistics.
// Ports: clk, rst_n (sync, active-low), inc (count enable), count (value, stops at all-ones).
module sat_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Hold at the top value instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/cache_miss_sequencer.sv
// Sequences CPU loads through a direct-mapped cache and main memory:
// lookup, line fetch on miss with timeout, fill, replay, respond.
// Ports:
//   cpu_req/cpu_addr in, cpu_ready/cpu_data/cpu_hit/cpu_err out   - CPU side
//   cache_lookup/cache_addr out, cache_hit/cache_rdata in          - cache read
//   cache_fill/cache_fill_line out                                 - cache line write
//   mem_req/mem_addr out, mem_valid/mem_line in                    - line fetch
//   hit_count/miss_count out                                       - saturating statistics
module cache_miss_sequencer #(
  parameter int unsigned ADDR_W      = cache_pkg::ADDR_W,
  parameter int unsigned DATA_W      = cache_pkg::DATA_W,
  parameter int unsigned LINE_W      = cache_pkg::LINE_W,
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ready,
  output logic [DATA_W-1:0] cpu_data,
  output logic              cpu_hit,
  output logic              cpu_err,
  output logic              cache_lookup,
  output logic [ADDR_W-1:0] cache_addr,
  input  logic              cache_hit,
  input  logic [DATA_W-1:0] cache_rdata,
  output logic              cache_fill,
  output logic [LINE_W-1:0] cache_fill_line,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [LINE_W-1:0] mem_line,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  import cache_pkg::*;

  // One extra value of headroom so MEM_TIMEOUT itself is representable.
  localparam int unsigned WAIT_W = $clog2(MEM_TIMEOUT + 2);

  state_t            state;
  state_t            state_nxt;
  logic              replay;
  logic [WAIT_W-1:0] wait_cnt;
  logic              timeout_c;
  logic              hit_inc_c;
  logic              miss_inc_c;

  assign timeout_c = (wait_cnt == WAIT_W'(MEM_TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and statistics strobes; replay lookups are never counted.
  always_comb begin
    state_nxt  = state;
    hit_inc_c  = 1'b0;
    miss_inc_c = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req) state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (cache_hit) begin
          state_nxt = RESP;
          hit_inc_c = !replay;
        end else begin
          state_nxt  = MISS_WAIT;
          miss_inc_c = !replay;
        end
      end
      MISS_WAIT: begin
        if (mem_valid)      state_nxt = FILL;
        else if (timeout_c) state_nxt = RESP;
      end
      FILL:    state_nxt = LOOKUP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_ready       <= 1'b0;
      cpu_data        <= '0;
      cpu_hit         <= 1'b0;
      cpu_err         <= 1'b0;
      cache_lookup    <= 1'b0;
      cache_addr      <= '0;
      cache_fill      <= 1'b0;
      cache_fill_line <= '0;
      mem_req         <= 1'b0;
      mem_addr        <= '0;
      replay          <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      cpu_ready    <= (state_nxt == RESP);
      cache_lookup <= (state_nxt == LOOKUP);
      cache_fill   <= (state_nxt == FILL);
      mem_req      <= (state_nxt == MISS_WAIT);
      case (state)
        IDLE: begin
          if (cpu_req) begin
            cache_addr <= cpu_addr;
            mem_addr   <= {cpu_addr[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
            replay     <= 1'b0;
          end
        end
        LOOKUP: begin
          if (cache_hit) begin
            cpu_data <= cache_rdata;
            cpu_hit  <= !replay;
            cpu_err  <= 1'b0;
          end else begin
            wait_cnt <= '0;
          end
        end
        MISS_WAIT: begin
          if (mem_valid) begin
            cache_fill_line <= mem_line;
          end else if (timeout_c) begin
            cpu_data <= '0;
            cpu_hit  <= 1'b0;
            cpu_err  <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        FILL: begin
          replay <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (hit_inc_c),
    .count (hit_count)
  );

  sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (miss_inc_c),
    .count (miss_count)
  );

endmodule

// File: tb/tb_cache_miss_sequencer.sv
// Bench for cache_miss_sequencer: direct-mapped cache model, memory responder
// with programmable latency, scoreboard of expected CPU responses.
module tb_cache_miss_sequencer;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LINE_W  = 512;
  localparam int unsigned TIMEOUT = 4;
  localparam int unsigned CNT_W   = 4;

  logic              clk;
  logic              rst_n;
  logic              cpu_req;
  logic [ADDR_W-1:0] cpu_addr;
  logic              cpu_ready;
  logic [DATA_W-1:0] cpu_data;
  logic              cpu_hit;
  logic              cpu_err;
  logic              cache_lookup;
  logic [ADDR_W-1:0] cache_addr;
  logic              cache_hit;
  logic [DATA_W-1:0] cache_rdata;
  logic              cache_fill;
  logic [LINE_W-1:0] cache_fill_line;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [LINE_W-1:0] mem_line;
  logic [CNT_W-1:0]  hit_count;
  logic [CNT_W-1:0]  miss_count;

  cache_miss_sequencer #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LINE_W(LINE_W),
    .MEM_TIMEOUT(TIMEOUT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_ready(cpu_ready),
    .cpu_data(cpu_data), .cpu_hit(cpu_hit), .cpu_err(cpu_err),
    .cache_lookup(cache_lookup), .cache_addr(cache_addr),
    .cache_hit(cache_hit), .cache_rdata(cache_rdata),
    .cache_fill(cache_fill), .cache_fill_line(cache_fill_line),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_valid(mem_valid), .mem_line(mem_line),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Memory contents: address-derived words, with one marker word in line 0x100.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] la;
    la = {a[31:6], 6'b0};
    if (la == 32'h0000_0100 && a[5:2] == 4'd1) return 32'hDEAD_BEEF;
    return 32'h5A5A_0000 ^ la ^ {28'h0, a[5:2]};
  endfunction

  function automatic logic [LINE_W-1:0] mem_line_for(input logic [31:0] la);
    logic [LINE_W-1:0] l;
    l = '0;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = mem_word(la | (32'(i) << 2));
    return l;
  endfunction

  // Direct-mapped cache model: 16 sets, index addr[9:6], tag addr[31:10].
  logic [LINE_W-1:0] c_data [16];
  logic [21:0]       c_tag  [16];
  logic [15:0]       c_vld = '0;

  always_comb begin
    cache_hit   = 1'b0;
    cache_rdata = '0;
    if (cache_lookup && c_vld[cache_addr[9:6]] && c_tag[cache_addr[9:6]] == cache_addr[31:10]) begin
      cache_hit   = 1'b1;
      cache_rdata = c_data[cache_addr[9:6]][{cache_addr[5:2], 5'b0} +: 32];
    end
  end

  always @(posedge clk) begin
    if (cache_fill) begin
      c_data[cache_addr[9:6]] <= cache_fill_line;
      c_tag[cache_addr[9:6]]  <= cache_addr[31:10];
      c_vld[cache_addr[9:6]]  <= 1'b1;
    end
  end

  // Memory input mux: automatic responder or hand-driven values.
  logic              mem_auto;
  int                mem_delay;
  logic              auto_valid;
  logic [LINE_W-1:0] auto_line;
  logic              man_valid;
  logic [LINE_W-1:0] man_line;
  assign mem_valid = mem_auto ? auto_valid : man_valid;
  assign mem_line  = mem_auto ? auto_line  : man_line;

  typedef struct {
    logic [31:0]      addr;
    logic [31:0]      maddr;
    logic [31:0]      data;
    logic             hit;
    logic             err;
    int               acc;
    int               lat;
    int               nreq;
    int               nfill;
    logic [CNT_W-1:0] hc;
    logic [CNT_W-1:0] mc;
  } exp_t;

  exp_t sbq[$];
  logic [CNT_W-1:0] exp_hits = '0;
  logic [CNT_W-1:0] exp_miss = '0;

  // Answers mem_req after mem_delay extra cycles; a negative delay never answers.
  task automatic responder();
    int cnt = 0;
    auto_valid = 1'b0;
    auto_line  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        if (mem_delay >= 0 && cnt == mem_delay) begin
          auto_valid = 1'b1;
          auto_line  = mem_line_for(mem_addr);
        end else begin
          auto_valid = 1'b0;
        end
        cnt++;
      end else begin
        auto_valid = 1'b0;
        cnt = 0;
      end
    end
  endtask

  // Pops the scoreboard on each cpu_ready and checks the whole transaction.
  task automatic monitor();
    int   nreq = 0;
    int   nfill = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nreq = 0;
        nfill = 0;
      end else begin
        if (mem_req) begin
          nreq++;
          if (sbq.size() > 0) chk("mem_addr", 64'(mem_addr), 64'(sbq[0].maddr));
        end
        if (cache_lookup && sbq.size() > 0) chk("cache_addr", 64'(cache_addr), 64'(sbq[0].addr));
        if (cache_fill) nfill++;
        if (cpu_ready) begin
          if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_ready: got cpu_ready=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = sbq.pop_front();
            chk("cpu_data",   64'(cpu_data), 64'(e.data));
            chk("cpu_hit",    64'(cpu_hit), 64'(e.hit));
            chk("cpu_err",    64'(cpu_err), 64'(e.err));
            chk("latency",    64'(cyc - e.acc), 64'(e.lat));
            chk("mem_req_n",  64'(nreq), 64'(e.nreq));
            chk("fill_n",     64'(nfill), 64'(e.nfill));
            chk("hit_count",  64'(hit_count), 64'(e.hc));
            chk("miss_count", 64'(miss_count), 64'(e.mc));
          end
          nreq = 0;
          nfill = 0;
        end
      end
    end
  endtask

  // One load: builds the expected record, drives the request, waits for cpu_ready.
  task automatic do_load(input logic [31:0] addr, input int delay,
                         input logic hit, input logic err, input int lat);
    exp_t e;
    bit   got;
    @(negedge clk);
    mem_delay = delay;
    if (hit) exp_hits = (exp_hits == {CNT_W{1'b1}}) ? exp_hits : exp_hits + CNT_W'(1);
    else     exp_miss = (exp_miss == {CNT_W{1'b1}}) ? exp_miss : exp_miss + CNT_W'(1);
    e.addr  = addr;
    e.maddr = {addr[31:6], 6'b0};
    e.data  = err ? 32'h0 : mem_word(addr);
    e.hit   = hit;
    e.err   = err;
    e.acc   = cyc;
    e.lat   = lat;
    e.nreq  = hit ? 0 : (err ? int'(TIMEOUT) + 1 : delay + 1);
    e.nfill = (!hit && !err) ? 1 : 0;
    e.hc    = exp_hits;
    e.mc    = exp_miss;
    sbq.push_back(e);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    got = 1'b0;
    for (int k = 0; k < 200 && !got; k++) begin
      @(negedge clk);
      cpu_addr = $urandom;
      if (cpu_ready) got = 1'b1;
    end
    cpu_req = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL ready_wait: got no cpu_ready expected one for addr %08h", addr);
      sbq.delete();
    end
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 64'(|{cpu_ready, cpu_data, cpu_hit, cpu_err, cache_lookup, cache_addr,
                  cache_fill, cache_fill_line, mem_req, mem_addr, hit_count, miss_count}), 64'd0);
  endtask

  typedef struct {
    logic [31:0] addr;
    int          delay;
    logic        hit;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int   acts;
    bit   seen;

    vecs[0] = '{32'h0000_0108, -1, 1'b1, 1'b0, 2};
    vecs[1] = '{32'h0000_013C, -1, 1'b1, 1'b0, 2};
    vecs[2] = '{32'h0000_1000,  0, 1'b0, 1'b0, 5};
    vecs[3] = '{32'h0000_1004, -1, 1'b1, 1'b0, 2};
    vecs[4] = '{32'h0000_2044,  2, 1'b0, 1'b0, 7};
    vecs[5] = '{32'h0000_0300,  4, 1'b0, 1'b0, 9};  // answered exactly at the timeout count
    vecs[6] = '{32'h0000_0304, -1, 1'b1, 1'b0, 2};
    vecs[7] = '{32'h0000_1400,  1, 1'b0, 1'b0, 6};  // evicts line 0x1000
    vecs[8] = '{32'h0000_1000,  0, 1'b0, 1'b0, 5};
    vecs[9] = '{32'h0000_1400,  3, 1'b0, 1'b0, 8};

    rst_n = 1'b0; cpu_req = 1'b0; cpu_addr = '0;
    mem_auto = 1'b0; mem_delay = -1; man_valid = 1'b0; man_line = '0;
    fork
      responder();
      monitor();
    join_none

    // Reset with random inputs.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_zero("reset_hold");
      cpu_req = 1'($urandom); cpu_addr = $urandom; man_valid = 1'($urandom);
      for (int j = 0; j < 16; j++) man_line[j*32 +: 32] = $urandom;
    end
    @(negedge clk);
    chk_zero("reset_last");
    rst_n = 1'b1; cpu_req = 1'b0; man_valid = 1'b0;
    @(negedge clk);
    chk_zero("after_release");
    mem_auto = 1'b1;

    // Cold miss, hit, timeout.
    do_load(32'h0000_0104, 3, 1'b0, 1'b0, 8);
    do_load(32'h0000_0104, -1, 1'b1, 1'b0, 2);
    do_load(32'h0000_0300, -1, 1'b0, 1'b1, int'(TIMEOUT) + 3);

    for (int i = 0; i < 10; i++) do_load(vecs[i].addr, vecs[i].delay, vecs[i].hit, vecs[i].err, vecs[i].lat);

    // Reset during MISS_WAIT, then a stray mem_valid after release.
    @(negedge clk);
    mem_delay = -1; cpu_req = 1'b1; cpu_addr = 32'h0000_5000;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      if (mem_req) seen = 1'b1;
    end
    chk("miss_wait_reached", 64'(seen), 64'd1);
    @(negedge clk);
    rst_n = 1'b0; cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_mem_req",   64'(mem_req), 64'd0);
    chk("rst_fill",      64'(cache_fill), 64'd0);
    chk("rst_hit_count", 64'(hit_count), 64'd0);
    chk("rst_miss_count", 64'(miss_count), 64'd0);
    rst_n = 1'b1; mem_auto = 1'b0;
    man_valid = 1'b1; man_line = mem_line_for(32'h0000_5000);
    @(negedge clk);
    man_valid = 1'b0;
    chk("late_valid_mem_req", 64'(mem_req), 64'd0);
    acts = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (cpu_ready || mem_req || cache_fill || cache_lookup) acts++;
    end
    chk("idle_after_reset", 64'(acts), 64'd0);
    exp_hits = '0; exp_miss = '0; mem_auto = 1'b1;

    // Hit counter saturation.
    for (int i = 0; i < 20; i++) do_load(32'h0000_0104, -1, 1'b1, 1'b0, 2);
    repeat (5) @(negedge clk);
    chk("sat_hit_stable",  64'(hit_count), 64'd15);
    chk("sat_miss_stable", 64'(miss_count), 64'd0);
    chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
